// File: rtl/cache_def.sv
// Shared cache/memory interface types and the memory arbiter state encoding.
package cache_def;

    typedef struct packed {
        logic [31:0]  addr;
        logic [127:0] data;
        logic         rw;
        logic         valid;
    } mem_req_type;

    typedef struct packed {
        logic [127:0] data;
        logic         ready;
    } mem_data_type;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_I,
        ARB_D,
        ARB_DONE
    } arb_state_type;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_I    = 2'b01;
    localparam logic [1:0] GRANT_D    = 2'b10;

endpackage

// File: rtl/mem_arbiter.sv
// Shares the main-memory port between I-cache and D-cache; one owner per
// transaction, response routed only to the owner, saturating per-port counters.
module mem_arbiter
    import cache_def::*;
#(
    parameter bit D_PRIORITY = 1'b1,
    parameter int CNT_W      = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  mem_req_type      i_req_i,
    output mem_data_type     i_data_o,
    input  mem_req_type      d_req_i,
    output mem_data_type     d_data_o,
    output mem_req_type      mem_req_o,
    input  mem_data_type     mem_data_i,
    output logic [1:0]       grant_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] no_i_txn_o,
    output logic [CNT_W-1:0] no_d_txn_o
);

    arb_state_type    state_q, state_d;
    logic             last_d_q, last_d_d;
    mem_req_type      req_q, req_d;
    logic             inc_i, inc_d;
    logic             pick_d;
    logic [CNT_W-1:0] cnt_i_q, cnt_d_q;

    always_comb begin
        state_d        = state_q;
        last_d_d       = last_d_q;
        req_d          = req_q;
        inc_i          = 1'b0;
        inc_d          = 1'b0;
        pick_d         = 1'b0;
        i_data_o.data  = mem_data_i.data;
        i_data_o.ready = 1'b0;
        d_data_o.data  = mem_data_i.data;
        d_data_o.ready = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                // On a tie, D wins in priority mode, otherwise the port not served last.
                pick_d = d_req_i.valid && (!i_req_i.valid || D_PRIORITY || !last_d_q);
                if (pick_d) begin
                    state_d  = ARB_D;
                    last_d_d = 1'b1;
                    req_d    = '{addr: d_req_i.addr, data: d_req_i.data, rw: d_req_i.rw, valid: 1'b1};
                end else if (i_req_i.valid) begin
                    state_d  = ARB_I;
                    last_d_d = 1'b0;
                    req_d    = '{addr: i_req_i.addr, data: i_req_i.data, rw: i_req_i.rw, valid: 1'b1};
                end
            end
            ARB_I: begin
                if (mem_data_i.ready) begin
                    i_data_o.ready = 1'b1;
                    inc_i          = 1'b1;
                    req_d.valid    = 1'b0;
                    state_d        = ARB_DONE;
                end
            end
            ARB_D: begin
                if (mem_data_i.ready) begin
                    d_data_o.ready = 1'b1;
                    inc_d          = 1'b1;
                    req_d.valid    = 1'b0;
                    state_d        = ARB_DONE;
                end
            end
            ARB_DONE: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ARB_IDLE;
            last_d_q <= 1'b0;
            req_q    <= '0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            req_q    <= req_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_i_q <= '0;
        end else if (inc_i && (cnt_i_q != '1)) begin
            cnt_i_q <= cnt_i_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_d_q <= '0;
        end else if (inc_d && (cnt_d_q != '1)) begin
            cnt_d_q <= cnt_d_q + CNT_W'(1);
        end
    end

    assign mem_req_o  = req_q;
    assign grant_o    = {state_q == ARB_D, state_q == ARB_I};
    assign busy_o     = (state_q != ARB_IDLE);
    assign no_i_txn_o = cnt_i_q;
    assign no_d_txn_o = cnt_d_q;

endmodule
